// File: rtl/button_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_reader_pkg
// Description : Shared constants for the push-button reader custom
//               instruction: opcode encodings, FSM state encodings,
//               bus and press-counter widths.
// Revision    : 1.0  initial release
// ============================================================================
package button_reader_pkg;

    localparam int CI_DATA_W   = 32;
    localparam int PRESS_CNT_W = 8;

    // Operation select, taken from dataa[1:0] at start
    localparam logic [1:0] OP_READ_LEVEL  = 2'd0;
    localparam logic [1:0] OP_READ_FLAGS  = 2'd1;
    localparam logic [1:0] OP_CLEAR_FLAGS = 2'd2;
    localparam logic [1:0] OP_READ_COUNT  = 2'd3;

    // Handshake FSM states
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/button_reader_ci_if.sv
`default_nettype none
// ============================================================================
// Module      : button_reader_ci_if
// Description : Nios II multi-cycle custom-instruction bus.
//               master : CPU side   (drives clk_en, start, dataa, datab)
//               slave  : block side (drives done, result)
// Revision    : 1.0  initial release
// ============================================================================
interface button_reader_ci_if;
    import button_reader_pkg::*;

    logic                 clk_en;
    logic                 start;
    logic [CI_DATA_W-1:0] dataa;
    logic [CI_DATA_W-1:0] datab;
    logic                 done;
    logic [CI_DATA_W-1:0] result;

    modport master (
        output clk_en, start, dataa, datab,
        input  done, result
    );

    modport slave (
        input  clk_en, start, dataa, datab,
        output done, result
    );

endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : One push-button: 2-flop synchronizer on the inverted raw
//               input, stability counter, debounced level and a one-cycle
//               press pulse on each accepted 0->1 transition.
// Ports       : clk, reset_n (async, active-low)
//               btn_n   raw asynchronous button, 0 = pressed
//               stable  debounced level, 1 = pressed
//               press   high in the cycle the stable level rises
// Revision    : 1.0  initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic btn_n,
    output logic      stable,
    output logic      press
);

    localparam int             CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    // The synchronized level has differed from the stable level long enough
    assign w_accept = (r_sync1 != r_stable) && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync0 <= ~btn_n;
            r_sync1 <= r_sync0;
            if (r_sync1 == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync1;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Pulse coincides with the edge that raises the stable level
    assign press  = w_accept && r_sync1;
    assign stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/button_reader_ci.sv
`default_nettype none
// ============================================================================
// Module      : button_reader_ci
// Description : Push-button reader custom instruction. Debounces the board
//               buttons, keeps sticky press flags and saturating press
//               counters, and serves READ_LEVEL / READ_FLAGS / CLEAR_FLAGS /
//               READ_COUNT over the start/done handshake (start->done = 2
//               enabled cycles).
// Ports       : clk, reset_n (async, active-low)
//               buttons_n  raw buttons, 0 = pressed
//               ci         custom-instruction bus (slave modport)
// Revision    : 1.0  initial release
// ============================================================================
module button_reader_ci
    import button_reader_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    input  wire logic [NUM_BUTTONS-1:0] buttons_n,
    button_reader_ci_if.slave           ci
);

    localparam logic [PRESS_CNT_W-1:0] C_CNT_MAX = '1;

    logic [NUM_BUTTONS-1:0]                  w_stable;
    logic [NUM_BUTTONS-1:0]                  w_press;
    logic [NUM_BUTTONS-1:0]                  r_flag;
    logic [NUM_BUTTONS-1:0][PRESS_CNT_W-1:0] r_cnt;

    state_t                 r_state;
    logic [1:0]             r_op;
    logic [7:0]             r_operand;
    logic [CI_DATA_W-1:0]   r_result;

    logic                   w_exec;
    logic [2:0]             w_idx;
    logic [PRESS_CNT_W-1:0] w_cnt_sel;
    logic [CI_DATA_W-1:0]   w_result;
    logic [NUM_BUTTONS-1:0] w_clr_flag;
    logic [NUM_BUTTONS-1:0] w_clr_cnt;
    logic                   w_unused_bits;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            button_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk     (clk),
                .reset_n (reset_n),
                .btn_n   (buttons_n[gi]),
                .stable  (w_stable[gi]),
                .press   (w_press[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    assign w_exec = ci.clk_en && (r_state == EXEC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_operand <= '0;
            r_result  <= '0;
        end else if (ci.clk_en) begin
            case (r_state)
                IDLE: begin
                    if (ci.start) begin
                        r_op      <= ci.dataa[1:0];
                        r_operand <= ci.datab[7:0];
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= w_result;
                    r_state  <= DONE;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ci.done   = (r_state == DONE);
    assign ci.result = r_result;

    // ------------------------------------------------------------------
    // Result mux and clear strobes. Indices at or above NUM_BUTTONS match
    // no button, so they read 0 and clear nothing.
    // ------------------------------------------------------------------
    assign w_idx = r_operand[2:0];

    always_comb begin
        w_cnt_sel = '0;
        w_clr_cnt = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (w_idx == 3'(i)) begin
                w_cnt_sel    = r_cnt[i];
                w_clr_cnt[i] = w_exec && (r_op == OP_READ_COUNT);
            end
        end
    end

    assign w_clr_flag = (w_exec && (r_op == OP_CLEAR_FLAGS)) ?
                        r_operand[NUM_BUTTONS-1:0] : '0;

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_READ_LEVEL:  w_result = CI_DATA_W'(w_stable);
            OP_READ_FLAGS:  w_result = CI_DATA_W'(r_flag);
            OP_CLEAR_FLAGS: w_result = CI_DATA_W'(r_flag);
            OP_READ_COUNT:  w_result = CI_DATA_W'(w_cnt_sel);
            default:        w_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Flags and counters run regardless of clk_en. A press landing on the
    // same edge as a clear takes priority over the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flag <= '0;
            r_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (w_press[i]) begin
                    r_flag[i] <= 1'b1;
                    if (r_cnt[i] != C_CNT_MAX)
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                end else begin
                    if (w_clr_flag[i])
                        r_flag[i] <= 1'b0;
                    if (w_clr_cnt[i])
                        r_cnt[i] <= '0;
                end
            end
        end
    end

    // Operand bits with no meaning for this block
    assign w_unused_bits = ^{ci.dataa[CI_DATA_W-1:2], ci.datab[CI_DATA_W-1:8], r_operand};

endmodule
`default_nettype wire

// File: tb/tb_button_reader_ci.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_reader_ci
// Description : Directed self-checking bench for button_reader_ci with
//               DEBOUNCE_CYCLES = 4 (raw edge -> stable change in 6 clocks).
// Revision    : 1.0  initial release
// ============================================================================
module tb_button_reader_ci;
    import button_reader_pkg::*;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NB-1:0] buttons_n;
    int            checks = 0;
    int            errors = 0;
    int            n_done;

    button_reader_ci_if ci();

    button_reader_ci #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .buttons_n (buttons_n),
        .ci        (ci)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents start for one enabled cycle; returns 1ns into cycle N+1
    task automatic start_op(input logic [1:0] op, input logic [31:0] b);
        @(negedge clk);
        ci.start = 1'b1;
        ci.dataa = {30'h0, op};
        ci.datab = b;
        tick(1);
        ci.start = 1'b0;
    endtask

    task automatic ci_op(input logic [1:0] op, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        start_op(op, b);
        chk({tag, "_done_n1"}, 32'(ci.done), 32'd0);
        tick(1);
        chk({tag, "_done_n2"}, 32'(ci.done), 32'd1);
        chk({tag, "_result"}, ci.result, exp);
        tick(1);
        chk({tag, "_done_n3"}, 32'(ci.done), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        buttons_n = '1;
        ci.clk_en = 1'b1;
        ci.start  = 1'b0;
        ci.dataa  = '0;
        ci.datab  = '0;

        // ---------------- reset and idle ----------------
        tick(3);
        chk("rst_done", 32'(ci.done), 32'd0);
        chk("rst_result", ci.result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ci_op(OP_READ_LEVEL, 32'd0, 32'd0, "lvl_idle");

        // Button 1 held for 10 cycles
        buttons_n[1] = 1'b0;
        tick(10);
        ci_op(OP_READ_LEVEL, 32'd0, 32'h2, "lvl_b1");
        ci_op(OP_READ_FLAGS, 32'd0, 32'h2, "flg_b1");
        buttons_n[1] = 1'b1;
        tick(10);
        ci_op(OP_READ_LEVEL, 32'd0, 32'h0, "lvl_rel");
        ci_op(OP_READ_COUNT, 32'd1, 32'd1, "cnt_b1");
        ci_op(OP_CLEAR_FLAGS, 32'hF, 32'h2, "clr_all1");
        ci_op(OP_READ_FLAGS, 32'd0, 32'h0, "flg_cleared");

        // ---------------- bounce rejection ----------------
        for (int k = 0; k < 5; k++) begin
            buttons_n[0] = 1'b0;
            tick(2);
            buttons_n[0] = 1'b1;
            tick(2);
        end
        tick(10);
        ci_op(OP_READ_FLAGS, 32'd0, 32'h0, "flg_bounce");
        ci_op(OP_READ_COUNT, 32'd0, 32'd0, "cnt_bounce");

        // ---------------- clear ----------------
        buttons_n = 4'b1010;
        tick(8);
        buttons_n = 4'b1111;
        tick(8);
        ci_op(OP_CLEAR_FLAGS, 32'h1, 32'h5, "clr_b0");
        ci_op(OP_READ_FLAGS, 32'd0, 32'h4, "flg_after_clr");

        // ---------------- counter saturation ----------------
        for (int p = 0; p < 300; p++) begin
            buttons_n[3] = 1'b0;
            tick(7);
            buttons_n[3] = 1'b1;
            tick(7);
        end
        ci_op(OP_READ_COUNT, 32'd3, 32'd255, "cnt_sat");
        ci_op(OP_READ_COUNT, 32'd3, 32'd0, "cnt_cleared");
        ci_op(OP_READ_COUNT, 32'd7, 32'd0, "cnt_idx7");
        ci_op(OP_READ_COUNT, 32'd2, 32'd1, "cnt_b2");
        ci_op(OP_CLEAR_FLAGS, 32'hF, 32'hC, "clr_all2");

        // ---------------- start repeated during EXEC ----------------
        @(negedge clk);
        ci.start = 1'b1;
        ci.dataa = {30'h0, OP_READ_COUNT};
        ci.datab = 32'd0;
        tick(1);
        chk("rep_done_n1", 32'(ci.done), 32'd0);
        tick(1);
        chk("rep_done_n2", 32'(ci.done), 32'd1);
        chk("rep_result", ci.result, 32'd1);
        ci.start = 1'b0;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            n_done += int'(ci.done);
        end
        chk("rep_extra_done", 32'(n_done), 32'd0);
        chk("rep_result_held", ci.result, 32'd1);

        // ---------------- clk_en stretch ----------------
        start_op(OP_READ_LEVEL, 32'd0);
        ci.clk_en = 1'b0;
        chk("ce_n1", 32'(ci.done), 32'd0);
        tick(1);
        chk("ce_n2", 32'(ci.done), 32'd0);
        tick(1);
        chk("ce_n3", 32'(ci.done), 32'd0);
        tick(1);
        ci.clk_en = 1'b1;
        chk("ce_n4", 32'(ci.done), 32'd0);
        tick(1);
        chk("ce_n5", 32'(ci.done), 32'd1);
        chk("ce_result", ci.result, 32'd0);
        ci.clk_en = 1'b0;
        tick(1);
        chk("ce_done_hold", 32'(ci.done), 32'd1);
        ci.clk_en = 1'b1;
        tick(1);
        chk("ce_done_drop", 32'(ci.done), 32'd0);

        // ---------------- reset during EXEC ----------------
        buttons_n[1] = 1'b0;
        tick(8);
        buttons_n[1] = 1'b1;
        tick(8);
        start_op(OP_READ_FLAGS, 32'd0);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            n_done += int'(ci.done);
        end
        chk("rst_exec_no_done", 32'(n_done), 32'd0);
        ci_op(OP_READ_FLAGS, 32'd0, 32'h0, "rst_exec_flags");
        ci_op(OP_READ_COUNT, 32'd1, 32'd0, "rst_exec_cnt");

        // ---------------- press on the CLEAR_FLAGS EXEC edge ----------------
        // Raw edge before E1 -> stable rises at E6; start captured at E5.
        @(negedge clk);
        buttons_n[2] = 1'b0;
        repeat (4) @(posedge clk);
        start_op(OP_CLEAR_FLAGS, 32'h4);
        tick(1);
        chk("race_done", 32'(ci.done), 32'd1);
        chk("race_result", ci.result, 32'h0);
        tick(1);
        ci_op(OP_READ_FLAGS, 32'd0, 32'h4, "race_flag_kept");
        ci_op(OP_READ_COUNT, 32'd2, 32'd1, "race_cnt");
        buttons_n[2] = 1'b1;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
